// File: rtl/vigna_md_if.sv
// vigna_md_if: request/response handshake bundle between execute and the M-extension unit.
interface vigna_md_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_func;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  in_op1;
  logic [XLEN-1:0]  in_op2;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result;
  modport master (
    output in_valid, in_func, in_tag, in_op1, in_op2, kill, out_ready,
    input  in_ready, out_valid, out_tag, out_result
  );
  modport slave (
    input  in_valid, in_func, in_tag, in_op1, in_op2, kill, out_ready,
    output in_ready, out_valid, out_tag, out_result
  );
endinterface

// File: rtl/vigna_md_unit.sv
// vigna_md_unit: iterative RV32M/RV64M multiply/divide, MUL_STEP multiplier bits per cycle,
// restoring divide at 1 bit per cycle, single outstanding request with tag and kill.
module vigna_md_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic        clk,
  input  logic        resetn,
  vigna_md_if.slave   bus
);
  localparam int CW   = $clog2(XLEN) + 1;
  localparam int NMUL = XLEN / MUL_STEP;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2*XLEN-1:0] a_q, a_d, acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, sgn1_q, sgn1_d, spec_q, spec_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [2:0]        f;
  logic              accept, s1, s2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2, quo, rem;
  logic [2*XLEN-1:0] sum, prod;
  logic [XLEN:0]     rdiff;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_result = result_q;
  always_comb begin
    f      = bus.in_func;
    accept = bus.in_valid && in_ready_q && !bus.kill;
    s1     = bus.in_op1[XLEN-1] && (f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd6);
    s2     = bus.in_op2[XLEN-1] && (f == 3'd1 || f == 3'd4 || f == 3'd6);
    mag1   = s1 ? -bus.in_op1 : bus.in_op1;
    mag2   = s2 ? -bus.in_op2 : bus.in_op2;
    div0   = bus.in_op2 == '0;
    ovf    = !f[0] && bus.in_op1 == {1'b1, {(XLEN-1){1'b0}}} && &bus.in_op2;
    sum    = acc_q;
    for (int i = 0; i < MUL_STEP; i++) sum = sum + (b_q[i] ? a_q << i : '0);
    rdiff  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem    = sgn1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    state_d  = state_q;
    func_d   = func_q;
    tag_d    = tag_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn1_d   = sgn1_q;
    spec_d   = spec_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        func_d   = f;
        tag_d    = bus.in_tag;
        neg_d    = s1 ^ s2;
        sgn1_d   = s1;
        a_d      = {{XLEN{1'b0}}, mag1};
        b_d      = mag2;
        acc_d    = f[2] ? {{XLEN{1'b0}}, mag1} : '0;
        cnt_d    = f[2] ? CW'(XLEN) : CW'(NMUL);
        spec_d   = f[2] && (div0 || ovf);
        result_d = div0 ? (f[1] ? bus.in_op1 : '1) : (f[1] ? '0 : bus.in_op1);
        state_d  = !f[2] ? MUL : (div0 || ovf) ? FIX : DIV;
      end
      MUL: begin
        acc_d   = sum;
        a_d     = a_q << MUL_STEP;
        b_d     = b_q >> MUL_STEP;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : MUL;
      end
      DIV: begin
        acc_d   = rdiff[XLEN] ? acc_q << 1 : {rdiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : DIV;
      end
      FIX: begin
        result_d = spec_q ? result_q : func_q[2] ? (func_q[1] ? rem : quo) :
                   func_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        cnt_d    = '0;
        state_d  = DONE;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (bus.kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      func_q      <= '0;
      tag_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      sgn1_q      <= 1'b0;
      spec_q      <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      tag_q       <= tag_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      sgn1_q      <= sgn1_d;
      spec_q      <= spec_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
